memory_controller: RTL and testbench

Sequences the single byte-wide RAM port and shares it between the instruction cache (word reads) and the load/store unit (byte/half/word reads and writes). Sits between both requesters and the external memory bus. Assembles and disassembles multi-byte accesses little-endian, one byte per cycle. Arbitrates round-robin on contention and aborts in-flight instruction fetches on pipeline flush.

---
 rtl/memory_controller_pkg.sv | 33 +++
 rtl/memory_controller.sv | 164 ++++++++++++++++
 tb/tb_memory_controller.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_controller_pkg.sv
// Shared definitions for the byte-wide RAM port sequencer: FSM states,
// LSU access-size encodings, grantee encoding and the size-to-byte-count helper.
package memory_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic {
    GNT_ICACHE = 1'b0,
    GNT_LSU    = 1'b1
  } grant_t;

  // Byte counter must reach N (=4) for the extra capture cycle of a read.
  localparam int CNT_W = 3;

  // Number of bus bytes for an LSU access; the illegal encoding 3 is a word.
  function automatic logic [CNT_W-1:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_controller.sv
// Byte-wide RAM port sequencer shared by the instruction cache (word fetches)
// and the load/store unit. Multi-byte accesses are split into one byte per
// cycle, little-endian. Contention is resolved round-robin; a flush aborts
// any instruction-cache transaction.
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  input  logic                  icache_read_valid,
  input  logic [ADDR_WIDTH-1:0] icache_read_addr,
  output logic                  icache_read_done,
  output logic [DATA_WIDTH-1:0] icache_read_data,
  input  logic                  lsu_valid,
  input  logic                  lsu_write,
  input  logic [1:0]            lsu_size,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  lsu_done,
  output logic [DATA_WIDTH-1:0] lsu_rdata
);

  state_t                state_q, state_d;
  grant_t                gnt_q, last_gnt_q, gnt_sel;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      nbytes_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] asm_q;
  logic                  ic_req, lsu_req, any_req;
  logic                  ic_abort;
  logic [1:0]            wr_idx, cap_idx;

  // A fetch presented during flush is not eligible for a grant.
  assign ic_req   = icache_read_valid && !flush;
  assign lsu_req  = lsu_valid;
  assign any_req  = ic_req || lsu_req;
  assign ic_abort = flush && (state_q != ST_IDLE) && (gnt_q == GNT_ICACHE);
  assign wr_idx   = cnt_q[1:0];
  // Byte arriving now belongs to the address issued one cycle earlier.
  assign cap_idx  = cnt_q[1:0] - 2'd1;

  // Round-robin chooser: on contention, favour the port not granted last.
  always_comb begin
    gnt_sel = GNT_LSU;
    if (ic_req && lsu_req) begin
      gnt_sel = (last_gnt_q == GNT_ICACHE) ? GNT_LSU : GNT_ICACHE;
    end else if (ic_req) begin
      gnt_sel = GNT_ICACHE;
    end
  end

  // State register; rdy low freezes the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a flush aborts an icache transaction from any busy state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = (gnt_sel == GNT_LSU && lsu_write) ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        if (cnt_q == nbytes_q) state_d = ST_DONE;
      end
      ST_WRITE: begin
        if (!io_buffer_full && (cnt_q == nbytes_q - 3'd1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (ic_abort) state_d = ST_IDLE;
  end

  // Control registers: byte counter, grantee, fairness history, read assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      gnt_q      <= GNT_ICACHE;
      last_gnt_q <= GNT_ICACHE;
      asm_q      <= '0;
    end else if (rdy) begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (any_req) begin
            gnt_q <= gnt_sel;
            asm_q <= '0;
          end
        end
        ST_READ: begin
          if (cnt_q != '0) asm_q[{cap_idx, 3'b000} +: 8] <= mem_din;
          cnt_q <= ic_abort ? '0 : cnt_q + 3'd1;
        end
        ST_WRITE: begin
          if (!io_buffer_full) cnt_q <= cnt_q + 3'd1;
        end
        default: begin
          cnt_q <= '0;
          if (!ic_abort) last_gnt_q <= gnt_q;
        end
      endcase
    end
  end

  // Request fields latched at grant time; they only matter while busy.
  always_ff @(posedge clk) begin
    if (rdy && state_q == ST_IDLE && any_req) begin
      if (gnt_sel == GNT_ICACHE) begin
        base_q   <= icache_read_addr;
        nbytes_q <= 3'd4;
      end else begin
        base_q   <= lsu_addr;
        nbytes_q <= size_to_bytes(lsu_size);
      end
      wdata_q <= lsu_wdata;
    end
  end

  // Bus outputs and done pulses decoded from the (frozen-when-idle-rdy) state.
  always_comb begin
    mem_addr         = '0;
    mem_dout         = 8'h00;
    mem_wr           = 1'b0;
    icache_read_done = 1'b0;
    lsu_done         = 1'b0;
    case (state_q)
      ST_READ: begin
        mem_addr = base_q + ADDR_WIDTH'(cnt_q);
      end
      ST_WRITE: begin
        mem_addr = base_q + ADDR_WIDTH'(cnt_q);
        mem_dout = wdata_q[{wr_idx, 3'b000} +: 8];
        mem_wr   = rdy && !io_buffer_full;
      end
      ST_DONE: begin
        if (gnt_q == GNT_LSU) lsu_done = 1'b1;
        else                  icache_read_done = !flush;
      end
      default: ;
    endcase
  end

  assign icache_read_data = asm_q;
  assign lsu_rdata        = asm_q;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: a read-only byte RAM model with one
// cycle of latency, hand-computed expectations for each scenario.
module tb_memory_controller;

  localparam int AW = 17;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          rdy;
  logic          flush;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic          io_buffer_full;
  logic          icache_read_valid;
  logic [AW-1:0] icache_read_addr;
  logic          icache_read_done;
  logic [DW-1:0] icache_read_data;
  logic          lsu_valid;
  logic          lsu_write;
  logic [1:0]    lsu_size;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata;
  logic          lsu_done;
  logic [DW-1:0] lsu_rdata;

  logic [7:0]    ram [0:(1<<AW)-1];
  logic [AW-1:0] addr_s;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_count = 0;
  int ic_done_cnt = 0;
  int lsu_done_cnt = 0;

  memory_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .flush             (flush),
    .mem_din           (mem_din),
    .mem_dout          (mem_dout),
    .mem_addr          (mem_addr),
    .mem_wr            (mem_wr),
    .io_buffer_full    (io_buffer_full),
    .icache_read_valid (icache_read_valid),
    .icache_read_addr  (icache_read_addr),
    .icache_read_done  (icache_read_done),
    .icache_read_data  (icache_read_data),
    .lsu_valid         (lsu_valid),
    .lsu_write         (lsu_write),
    .lsu_size          (lsu_size),
    .lsu_addr          (lsu_addr),
    .lsu_wdata         (lsu_wdata),
    .lsu_done          (lsu_done),
    .lsu_rdata         (lsu_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mid-cycle sampling of the bus and done strobes.
  always @(negedge clk) begin
    addr_s <= mem_addr;
    if (mem_wr)           wr_count     <= wr_count + 1;
    if (icache_read_done) ic_done_cnt  <= ic_done_cnt + 1;
    if (lsu_done)         lsu_done_cnt <= lsu_done_cnt + 1;
  end

  // RAM returns the byte for the address seen during the previous cycle.
  always @(posedge clk) mem_din <= ram[addr_s];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w0;
    int ic0;
    int ls0;
    int found;
    logic who;

    rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    icache_read_valid = 1'b0; icache_read_addr = '0;
    lsu_valid = 1'b0; lsu_write = 1'b0; lsu_size = 2'd0; lsu_addr = '0; lsu_wdata = '0;

    ram[17'h00100] = 8'h13; ram[17'h00101] = 8'h05; ram[17'h00102] = 8'h00; ram[17'h00103] = 8'h00;
    ram[17'h00300] = 8'hAA; ram[17'h00301] = 8'hBB; ram[17'h00302] = 8'hCC; ram[17'h00303] = 8'hDD;
    ram[17'h00400] = 8'h11; ram[17'h00401] = 8'h22; ram[17'h00402] = 8'h33; ram[17'h00403] = 8'h44;
    ram[17'h00600] = 8'h55; ram[17'h00601] = 8'h66; ram[17'h00602] = 8'h77; ram[17'h00603] = 8'h88;
    ram[17'h00607] = 8'h9C;
    ram[17'h00700] = 8'h01; ram[17'h00701] = 8'h02; ram[17'h00702] = 8'h03; ram[17'h00703] = 8'h04;

    // Reset state
    repeat (2) tick;
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    check("rst_dones", 32'({icache_read_done, lsu_done}), 32'h0);
    check("rst_ic_data", icache_read_data, 32'h0);
    check("rst_lsu_data", lsu_rdata, 32'h0);

    // Icache word fetch from 0x100
    rst = 1'b0;
    icache_read_valid = 1'b1; icache_read_addr = 17'h00100;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("ic_addr", 32'(mem_addr), 32'h100 + 32'(i));
      check("ic_no_done_early", 32'(icache_read_done), 32'h0);
    end
    tick;
    check("ic_extra_no_done", 32'(icache_read_done), 32'h0);
    tick;
    check("ic_done", 32'(icache_read_done), 32'h1);
    check("ic_lsu_quiet", 32'(lsu_done), 32'h0);
    check("ic_data", icache_read_data, 32'h00000513);
    icache_read_valid = 1'b0;
    tick;
    check("ic_done_once", 32'(icache_read_done), 32'h0);
    check("ic_idle_addr", 32'(mem_addr), 32'h0);

    // LSU half store 0xBEEF to 0x202
    w0 = wr_count;
    lsu_valid = 1'b1; lsu_write = 1'b1; lsu_size = 2'd1; lsu_addr = 17'h00202; lsu_wdata = 32'h0000BEEF;
    tick;
    check("st_wr0", 32'(mem_wr), 32'h1);
    check("st_addr0", 32'(mem_addr), 32'h202);
    check("st_dout0", 32'(mem_dout), 32'hEF);
    tick;
    check("st_wr1", 32'(mem_wr), 32'h1);
    check("st_addr1", 32'(mem_addr), 32'h203);
    check("st_dout1", 32'(mem_dout), 32'hBE);
    tick;
    check("st_done", 32'(lsu_done), 32'h1);
    check("st_done_no_wr", 32'(mem_wr), 32'h0);
    lsu_valid = 1'b0; lsu_write = 1'b0;
    tick;
    check("st_wr_total", 32'(wr_count - w0), 32'd2);

    // Round-robin from reset: LSU, icache, LSU
    rst = 1'b1;
    tick;
    rst = 1'b0;
    icache_read_valid = 1'b1; icache_read_addr = 17'h00300;
    lsu_valid = 1'b1; lsu_write = 1'b0; lsu_size = 2'd2; lsu_addr = 17'h00400;
    for (int r = 0; r < 3; r++) begin
      found = 0;
      for (int c = 0; c < 20; c++) begin
        tick;
        if (icache_read_done || lsu_done) begin
          found = 1;
          break;
        end
      end
      check("rr_seen", 32'(found), 32'h1);
      who = lsu_done;
      check("rr_winner", 32'(who), 32'((r != 1) ? 1 : 0));
      check("rr_single", 32'(icache_read_done & lsu_done), 32'h0);
      if (who) check("rr_lsu_data", lsu_rdata, 32'h44332211);
      else     check("rr_ic_data", icache_read_data, 32'hDDCCBBAA);
      if (r == 2) begin
        lsu_valid = 1'b0; icache_read_valid = 1'b0;
      end else if (who) begin
        lsu_valid = 1'b0;
      end else begin
        icache_read_valid = 1'b0;
      end
      tick;
      check("rr_gap", 32'(icache_read_done | lsu_done), 32'h0);
      if (r != 2) begin
        if (who) lsu_valid = 1'b1;
        else     icache_read_valid = 1'b1;
      end
    end
    tick;

    // Word store with 3 cycles of backpressure on byte 1
    w0 = wr_count;
    lsu_valid = 1'b1; lsu_write = 1'b1; lsu_size = 2'd2; lsu_addr = 17'h00500; lsu_wdata = 32'hA1B2C3D4;
    tick;
    check("bp_dout0", 32'(mem_dout), 32'hD4);
    check("bp_wr0", 32'(mem_wr), 32'h1);
    tick;
    io_buffer_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_held_wr", 32'(mem_wr), 32'h0);
      check("bp_held_addr", 32'(mem_addr), 32'h501);
      check("bp_held_done", 32'(lsu_done), 32'h0);
      tick;
    end
    io_buffer_full = 1'b0;
    #1;
    check("bp_reissue_wr", 32'(mem_wr), 32'h1);
    check("bp_reissue_dout", 32'(mem_dout), 32'hC3);
    tick;
    check("bp_addr2", 32'(mem_addr), 32'h502);
    check("bp_dout2", 32'(mem_dout), 32'hB2);
    tick;
    check("bp_addr3", 32'(mem_addr), 32'h503);
    check("bp_dout3", 32'(mem_dout), 32'hA1);
    tick;
    check("bp_done", 32'(lsu_done), 32'h1);
    lsu_valid = 1'b0; lsu_write = 1'b0;
    tick;
    check("bp_wr_total", 32'(wr_count - w0), 32'd4);

    // Flush during the 3rd byte of a fetch; pending LSU byte load then runs
    ic0 = ic_done_cnt;
    icache_read_valid = 1'b1; icache_read_addr = 17'h00600;
    lsu_valid = 1'b1; lsu_write = 1'b0; lsu_size = 2'd0; lsu_addr = 17'h00607;
    tick;
    check("fl_ic_granted", 32'(mem_addr), 32'h600);
    tick;
    tick;
    check("fl_addr_b2", 32'(mem_addr), 32'h602);
    flush = 1'b1;
    #1;
    check("fl_no_done", 32'(icache_read_done), 32'h0);
    tick;
    check("fl_idle_addr", 32'(mem_addr), 32'h0);
    check("fl_idle_wr", 32'(mem_wr), 32'h0);
    tick;
    check("fl_lsu_addr", 32'(mem_addr), 32'h607);
    flush = 1'b0; icache_read_valid = 1'b0;
    tick;
    tick;
    check("fl_lsu_done", 32'(lsu_done), 32'h1);
    check("fl_lsu_data", lsu_rdata, 32'h0000009C);
    check("fl_ic_never_done", 32'(ic_done_cnt - ic0), 32'h0);
    lsu_valid = 1'b0;
    tick;

    // rdy low mid word load, then reset mid-transaction
    lsu_valid = 1'b1; lsu_write = 1'b0; lsu_size = 2'd2; lsu_addr = 17'h00700;
    tick;
    check("rdy_addr0", 32'(mem_addr), 32'h700);
    tick;
    check("rdy_addr1", 32'(mem_addr), 32'h701);
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      check("rdy_frozen_addr", 32'(mem_addr), 32'h701);
      check("rdy_frozen_done", 32'(lsu_done), 32'h0);
    end
    rdy = 1'b1;
    tick;
    check("rdy_resumed", 32'(mem_addr), 32'h702);
    ls0 = lsu_done_cnt;
    rst = 1'b1;
    tick;
    check("mrst_addr", 32'(mem_addr), 32'h0);
    check("mrst_wr", 32'(mem_wr), 32'h0);
    check("mrst_dout", 32'(mem_dout), 32'h0);
    check("mrst_rdata", lsu_rdata, 32'h0);
    check("mrst_idata", icache_read_data, 32'h0);
    rst = 1'b0;
    lsu_valid = 1'b0;
    repeat (8) tick;
    check("mrst_no_done", 32'(lsu_done_cnt - ls0), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
